// File: rtl/temporizador_pkg.sv
// rtl/temporizador_pkg.sv - shared state encodings for countdown timers and robot control units
package temporizador_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CONTA  = 2'd1,
    PAUSA  = 2'd2,
    FIM    = 2'd3
  } estado_t;

endpackage

// File: rtl/temporizador_regressivo.sv
// rtl/temporizador_regressivo.sv - loadable countdown timer with pause, cancel and half-way flag
module temporizador_regressivo
  import temporizador_pkg::*;
#(
  parameter int N = 7
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         carrega,
  input  logic [N-1:0] valor,
  input  logic         inicia,
  input  logic         pausa,
  input  logic         cancela,
  input  logic         tick,
  output logic [N-1:0] Q,
  output logic         ocupado,
  output logic         meio,
  output logic         fim,
  output logic [1:0]   db_estado
);

  estado_t      estado_q;
  logic [N-1:0] q_q;
  logic [N-1:0] metade_q;
  logic [N-1:0] q_ini;

  // Count that inicia sees: a load in the same cycle takes effect immediately
  always_comb begin
    q_ini = carrega ? valor : q_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      q_q      <= '0;
      metade_q <= '0;
    end else if (cancela) begin
      estado_q <= OCIOSO;
      q_q      <= '0;
      metade_q <= '0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (carrega) begin
            q_q      <= valor;
            metade_q <= valor >> 1;
          end
          if (inicia) begin
            estado_q <= (q_ini == '0) ? FIM : CONTA;
          end
        end
        CONTA: begin
          if (pausa) begin
            estado_q <= PAUSA;
          end else if (tick) begin
            // Saturate at zero; the last tick moves straight to FIM
            if (q_q <= N'(1)) begin
              q_q      <= '0;
              estado_q <= FIM;
            end else begin
              q_q <= q_q - N'(1);
            end
          end
        end
        PAUSA: begin
          if (!pausa) begin
            estado_q <= CONTA;
          end
        end
        FIM: begin
          if (carrega) begin
            q_q      <= valor;
            metade_q <= valor >> 1;
          end
          estado_q <= OCIOSO;
        end
        default: begin
          estado_q <= OCIOSO;
        end
      endcase
    end
  end

  assign ocupado   = (estado_q == CONTA) || (estado_q == PAUSA);
  assign meio      = ocupado && (q_q <= metade_q);
  assign fim       = (estado_q == FIM);
  assign Q         = q_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_temporizador_regressivo.sv
// tb/tb_temporizador_regressivo.sv - directed self-checking bench for temporizador_regressivo
module tb_temporizador_regressivo;

  localparam int N = 7;

  logic         clock = 1'b0;
  logic         reset;
  logic         carrega;
  logic [N-1:0] valor;
  logic         inicia;
  logic         pausa;
  logic         cancela;
  logic         tick;
  logic [N-1:0] Q;
  logic         ocupado;
  logic         meio;
  logic         fim;
  logic [1:0]   db_estado;

  int errors = 0;
  int checks = 0;

  temporizador_regressivo #(.N(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .carrega   (carrega),
    .valor     (valor),
    .inicia    (inicia),
    .pausa     (pausa),
    .cancela   (cancela),
    .tick      (tick),
    .Q         (Q),
    .ocupado   (ocupado),
    .meio      (meio),
    .fim       (fim),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input int eq, input int est, input int ocu,
                           input int mei, input int fi);
    check_eq({tag, " Q"}, 32'(Q), 32'(eq));
    check_eq({tag, " estado"}, 32'(db_estado), 32'(est));
    check_eq({tag, " ocupado"}, 32'(ocupado), 32'(ocu));
    check_eq({tag, " meio"}, 32'(meio), 32'(mei));
    check_eq({tag, " fim"}, 32'(fim), 32'(fi));
  endtask

  initial begin
    reset = 1'b1; carrega = 1'b0; valor = '0; inicia = 1'b0;
    pausa = 1'b0; cancela = 1'b0; tick = 1'b0;
    #1;
    step();
    check_all("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    step();
    check_all("idle", 0, 0, 0, 0, 0);

    // Load 5 and start together, tick every cycle
    valor = 7'd5; carrega = 1'b1; inicia = 1'b1; tick = 1'b1;
    step();
    carrega = 1'b0; inicia = 1'b0;
    check_all("c5 start", 5, 1, 1, 0, 0);
    for (int k = 4; k >= 1; k--) begin
      step();
      check_all($sformatf("c5 q%0d", k), k, 1, 1, (k <= 2) ? 1 : 0, 0);
    end
    step();
    check_all("c5 fim", 0, 3, 0, 0, 1);
    step();
    check_all("c5 after", 0, 0, 0, 0, 0);
    step();
    check_all("c5 hold", 0, 0, 0, 0, 0);

    // Load 0 then inicia: straight to FIM
    tick = 1'b0; valor = 7'd0; carrega = 1'b1;
    step();
    carrega = 1'b0;
    check_all("z load", 0, 0, 0, 0, 0);
    inicia = 1'b1;
    step();
    inicia = 1'b0;
    check_all("z fim", 0, 3, 0, 0, 1);
    step();
    check_all("z after", 0, 0, 0, 0, 0);

    // Load 6, hold without tick, pause at 4
    valor = 7'd6; carrega = 1'b1; inicia = 1'b1; tick = 1'b0;
    step();
    carrega = 1'b0; inicia = 1'b0;
    check_all("p start", 6, 1, 1, 0, 0);
    step();
    check_all("p notick", 6, 1, 1, 0, 0);
    tick = 1'b1;
    step();
    check_all("p q5", 5, 1, 1, 0, 0);
    step();
    check_all("p q4", 4, 1, 1, 0, 0);
    pausa = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_all($sformatf("p hold%0d", k), 4, 2, 1, 0, 0);
    end
    pausa = 1'b0;
    step();
    check_all("p exit", 4, 1, 1, 0, 0);
    for (int k = 3; k >= 1; k--) begin
      step();
      check_all($sformatf("p q%0d", k), k, 1, 1, (k <= 3) ? 1 : 0, 0);
    end
    step();
    check_all("p fim", 0, 3, 0, 0, 1);
    tick = 1'b0;
    step();
    check_all("p after", 0, 0, 0, 0, 0);

    // Load 7, run to 3, carrega/inicia ignored, then cancela
    valor = 7'd7; carrega = 1'b1; inicia = 1'b1; tick = 1'b1;
    step();
    carrega = 1'b0; inicia = 1'b0;
    check_all("x start", 7, 1, 1, 0, 0);
    for (int k = 6; k >= 3; k--) begin
      step();
      check_all($sformatf("x q%0d", k), k, 1, 1, (k <= 3) ? 1 : 0, 0);
    end
    tick = 1'b0; valor = 7'd2; carrega = 1'b1; inicia = 1'b1;
    step();
    carrega = 1'b0; inicia = 1'b0;
    check_all("x ignore", 3, 1, 1, 1, 0);
    cancela = 1'b1; tick = 1'b1; carrega = 1'b1;
    step();
    cancela = 1'b0; tick = 1'b0; carrega = 1'b0;
    check_all("x cancel", 0, 0, 0, 0, 0);
    step();
    check_all("x nofim", 0, 0, 0, 0, 0);

    // Reset mid-count overrides carrega/inicia
    valor = 7'd4; carrega = 1'b1; inicia = 1'b1; tick = 1'b1;
    step();
    carrega = 1'b0; inicia = 1'b0;
    check_all("r start", 4, 1, 1, 0, 0);
    step();
    step();
    check_all("r q2", 2, 1, 1, 1, 0);
    reset = 1'b1; carrega = 1'b1; inicia = 1'b1; cancela = 1'b1; valor = 7'd9;
    step();
    reset = 1'b0; cancela = 1'b0;
    check_all("r reset", 0, 0, 0, 0, 0);
    valor = 7'd3;
    step();
    carrega = 1'b0; inicia = 1'b0;
    check_all("r3 start", 3, 1, 1, 0, 0);
    step();
    check_all("r3 q2", 2, 1, 1, 0, 0);
    step();
    check_all("r3 q1", 1, 1, 1, 1, 0);
    step();
    check_all("r3 fim", 0, 3, 0, 0, 1);
    // Load accepted while in FIM
    tick = 1'b0; valor = 7'd5; carrega = 1'b1;
    step();
    carrega = 1'b0;
    check_all("fim load", 5, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/temporizador_regressivo.md
TEMPORIZADOR_REGRESSIVO -- requirements
Module: temporizador_regressivo

Interface
REQ-001 Parameter N SHALL default to 7; it is the counter and load width in bits.
REQ-002 Port clock, input, 1, the single clock; all state changes on rising edge.
REQ-003 Port reset, input, 1, synchronous active-high reset.
REQ-004 Port carrega, input, 1, loads valor into the count and half-threshold registers.
REQ-005 Port valor, input, N, initial count to load.
REQ-006 Port inicia, input, 1, starts the countdown.
REQ-007 Port pausa, input, 1, level; holds the count while high.
REQ-008 Port cancela, input, 1, aborts: returns to OCIOSO and clears Q.
REQ-009 Port tick, input, 1, decrement enable (prescaler strobe).
REQ-010 Port Q, output, N, current remaining count.
REQ-011 Port ocupado, output, 1, high in CONTA or PAUSA.
REQ-012 Port meio, output, 1, high in CONTA or PAUSA when Q <= metade.
REQ-013 Port fim, output, 1, one-cycle completion pulse.
REQ-014 Port db_estado, output, 2, state encoding for debug.

Function
REQ-015 FSM states SHALL be OCIOSO=0, CONTA=1, PAUSA=2, FIM=3.
REQ-016 OCIOSO or FIM with carrega=1: Q <= valor, metade <= valor>>1 (floor).
REQ-017 OCIOSO with inicia=1 SHALL go to CONTA; if carrega=1 in the same cycle, Q starts from valor.
REQ-018 inicia with effective Q==0 SHALL go directly to FIM; no decrement occurs.
REQ-019 In CONTA with tick=1 and pausa=0, Q <= Q-1; no decrement when tick=0.
REQ-020 In CONTA, Q==1 with tick=1 and pausa=0: Q <= 0 and next state FIM; Q SHALL NOT wrap below 0.
REQ-021 CONTA with pausa=1 SHALL go to PAUSA without decrement, even if tick=1.
REQ-022 PAUSA with pausa=0 SHALL return to CONTA; no decrement in the exit cycle.
REQ-023 FIM SHALL last exactly one cycle, then go to OCIOSO; fim=1 only in FIM.
REQ-024 Q SHALL hold 0 in FIM and after it, until the next carrega.
REQ-025 carrega and inicia SHALL be ignored in CONTA and PAUSA.
REQ-026 cancela SHALL take priority over all inputs except reset: next state OCIOSO, Q <= 0, metade <= 0, no fim pulse.
REQ-027 meio and ocupado SHALL be combinational from registered state, Q and metade; fim SHALL be decoded from state.
REQ-028 Latency SHALL be valor ticks from entering CONTA to Q==0, with fim one cycle after the decrementing tick.

Reset
REQ-029 reset=1 at a clock edge: state OCIOSO, Q=0, metade=0, so fim=0, meio=0, ocupado=0, db_estado=0.
REQ-030 reset SHALL override cancela, carrega and inicia in the same cycle, including mid-countdown.

Structure
REQ-031 State encodings SHALL live in a shared package/include (temporizador_pkg) reused by the robot control units.
REQ-032 The block SHALL be one module with no sub-modules: FSM next-state logic, a registered Q, and a registered metade.

Verification
REQ-033 Load 5, inicia, tick every cycle -> Q goes 5,4,3,2,1,0; meio high from Q=2; fim one pulse after Q reaches 0; ocupado low after.
REQ-034 Load 0, inicia -> FIM next cycle, fim=1 for 1 cycle, Q stays 0.
REQ-035 Load 6, run to Q=4, pausa=1 for 3 cycles with tick=1 -> Q holds 4, db_estado=2; release -> count resumes to 0.
REQ-036 Load 7, run to Q=3, cancela -> OCIOSO, Q=0, no fim pulse; carrega during CONTA is ignored.
REQ-037 reset asserted at Q=2 mid-count -> all outputs 0 next edge; carrega+inicia same cycle with valor=3 -> 3 ticks to fim.
